// File: rtl/instr_queue.sv
// ============================================================================
// Module   : instr_queue
// Purpose  : Fetch-to-decode instruction FIFO with flush and backpressure.
//            Define IQ_PREDECODE_EN to add the out_is_ctrl predecode flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_queue #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_instr,
    input  logic [W-1:0]             in_pc,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [W-1:0]             out_instr,
    output logic [W-1:0]             out_pc,
    input  logic                     out_ready,
    input  logic                     flush,
`ifdef IQ_PREDECODE_EN
    output logic                     out_is_ctrl,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_full = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw-1:0]   c_one  = c_aw'(1);

    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw:0]   count_q,  count_d;
    logic            w_push;
    logic            w_pop;

    logic [W-1:0]    instr_mem_q [DEPTH];
    logic [W-1:0]    pc_mem_q    [DEPTH];

    // Status outputs come only from registered occupancy.
    assign in_ready  = (count_q != c_full);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + c_one;
            if (w_pop)  rd_ptr_d = rd_ptr_q + c_one;
            if (w_push && !w_pop)      count_d = count_q + 1'b1;
            else if (w_pop && !w_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left unreset; a flushed push must not land in a slot.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

`ifdef IQ_PREDECODE_EN
    logic ctrl_mem_q [DEPTH];
    logic w_is_ctrl;

    assign w_is_ctrl = (in_instr[6:0] == 7'b1100011) ||
                       (in_instr[6:0] == 7'b1101111) ||
                       (in_instr[6:0] == 7'b1100111);

    always_ff @(posedge clk) begin
        if (w_push && !flush) ctrl_mem_q[wr_ptr_q] <= w_is_ctrl;
    end

    assign out_is_ctrl = out_valid ? ctrl_mem_q[rd_ptr_q] : 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_queue.sv
// ============================================================================
// Module   : tb_instr_queue
// Purpose  : Directed self-checking bench for instr_queue (DEPTH=4, W=32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        flush;
    logic [2:0]  count;
`ifdef IQ_PREDECODE_EN
    logic        out_is_ctrl;
`endif

    int checks = 0;
    int errors = 0;

    instr_queue #(.W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .flush     (flush),
`ifdef IQ_PREDECODE_EN
        .out_is_ctrl (out_is_ctrl),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    logic [31:0] words [4];

    initial begin
        words[0] = 32'h00500093;
        words[1] = 32'h00A00113;
        words[2] = 32'h002081B3;
        words[3] = 32'h00000013;

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0; flush = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count",     {29'd0, count},     32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_instr", out_instr,          32'd0);
        chk("rst_out_pc",    out_pc,             32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Two entries held, then async reset mid-cycle.
        drive(1'b1, 32'h11111111, 32'd0); tick();
        drive(1'b1, 32'h22222222, 32'd4); tick();
        drive(1'b0, 32'd0, 32'd0);
        chk("pre_rst_count", {29'd0, count}, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_count",     {29'd0, count},     32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        #1 rst = 1'b0;
        tick();

        // Fill with decode stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[i], 32'(4 * i));
            tick();
            chk("fill_count", {29'd0, count}, 32'(i + 1));
        end
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_head_instr", out_instr, 32'h00500093);
        drive(1'b1, 32'hBAD0BAD0, 32'd100); tick();
        chk("full_ignored_count", {29'd0, count}, 32'd4);
        drive(1'b0, 32'd0, 32'd0);

        // Drain in order.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", {31'd0, out_valid}, 32'd1);
            chk("drain_instr", out_instr, words[i]);
            chk("drain_pc",    out_pc,    32'(4 * i));
            tick();
        end
        chk("drained_valid", {31'd0, out_valid}, 32'd0);
        chk("drained_count", {29'd0, count},     32'd0);
        chk("drained_instr", out_instr,          32'd0);
        out_ready = 1'b0;

        // Full with simultaneous push attempt and pop.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[i], 32'(4 * i));
            tick();
        end
        chk("refill_count", {29'd0, count}, 32'd4);
        drive(1'b1, 32'hCAFECAFE, 32'd200);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 32'd0, 32'd0);
        chk("full_pop_count", {29'd0, count}, 32'd3);
        for (int i = 1; i < 4; i++) begin
            chk("full_pop_order", out_instr, words[i]);
            tick();
        end
        chk("full_pop_empty", {31'd0, out_valid}, 32'd0);

        // Steady stream: one push and one pop per cycle.
        drive(1'b1, 32'h00001000, 32'd0);
        #1;
        chk("stream_no_bypass", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h00001000 + 32'(i), 32'(4 * i));
            tick();
            chk("stream_count", {29'd0, count}, 32'd1);
            chk("stream_pc",    out_pc,         32'(4 * i));
        end
        drive(1'b0, 32'd0, 32'd0);
        tick();
        chk("stream_end_count", {29'd0, count}, 32'd0);
        out_ready = 1'b0;

        // Flush overrides simultaneous push and pop.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00002000 + 32'(i), 32'(64 + 4 * i));
            tick();
        end
        chk("pre_flush_count", {29'd0, count}, 32'd3);
        drive(1'b1, 32'hDEADBEEF, 32'd76);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        chk("flush_count",     {29'd0, count},     32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
        chk("flush_out_instr", out_instr,          32'd0);
        tick();
        chk("flush_stays_empty", {29'd0, count}, 32'd0);
        drive(1'b1, 32'h00003000, 32'd128); tick();
        drive(1'b0, 32'd0, 32'd0);
        chk("post_flush_instr", out_instr, 32'h00003000);
        chk("post_flush_pc",    out_pc,    32'd128);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("post_flush_empty", {29'd0, count}, 32'd0);

`ifdef IQ_PREDECODE_EN
        chk("pd_empty", {31'd0, out_is_ctrl}, 32'd0);
        drive(1'b1, 32'hFE000EE3, 32'd0); tick();
        drive(1'b1, 32'h00000013, 32'd4); tick();
        drive(1'b1, 32'h0000006F, 32'd8); tick();
        drive(1'b0, 32'd0, 32'd0);
        chk("pd_beq", {31'd0, out_is_ctrl}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("pd_addi", {31'd0, out_is_ctrl}, 32'd0);
        tick();
        chk("pd_jal", {31'd0, out_is_ctrl}, 32'd1);
        tick();
        chk("pd_drained", {31'd0, out_is_ctrl}, 32'd0);
        out_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
